// File: rtl/dmem_pkg.sv
// Shared constants and types for the line-granular data memory.
package dmem_pkg;

    localparam int LINE_W     = 256;
    localparam int OFFSET_W   = 5;
    localparam int KEY_ADDR_W = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } dmem_state_t;

    // Identifies a cache request; a held enable only counts as new if this changes.
    typedef struct packed {
        logic [KEY_ADDR_W-1:0] line_addr;
        logic                  write;
    } req_key_t;

    function automatic logic line_out_of_range(input req_key_t key, input int idx_w);
        return |(key.line_addr >> idx_w);
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port DEPTH x LINE_W line storage with write enable and registered read.
module dmem_line_array #(
    parameter int DEPTH  = 512,
    parameter int LINE_W = 256
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [LINE_W-1:0]        wdata,
    output logic [LINE_W-1:0]        rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_line_ctrl.sv
// Fixed-latency 256-bit line memory behind the data cache, one ack per distinct request.
// Optional macro DMEM_RANGE_CHECK_EN adds err_o and suppresses out-of-range accesses.
module dmem_line_ctrl #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = dmem_pkg::LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              err_o
`endif
);

    import dmem_pkg::*;

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] LOAD_CNT = 8'(LATENCY - 1);

    dmem_state_t       state, state_next;
    logic [7:0]        counter;
    req_key_t          req_key, last_done, in_key, cur_key;
    logic [LINE_W-1:0] req_data, cur_data, arr_rdata;
    logic              done_valid, rd_zero;
    logic              accept, enter_ack, cur_oor;
    logic              arr_we, arr_re;
    logic [IDX_W-1:0]  arr_idx;
    logic [4:0]        unused_offset;

    assign unused_offset = addr_i[OFFSET_W-1:0];
    assign in_key        = '{line_addr: addr_i[31:OFFSET_W], write: write_i};
    assign accept        = (state == IDLE) && enable_i && (!done_valid || (in_key != last_done));

    // With LATENCY=1 the array is accessed straight from the IDLE inputs.
    always_comb begin
        cur_key  = (state == IDLE) ? in_key : req_key;
        cur_data = (state == IDLE) ? data_i : req_data;
`ifdef DMEM_RANGE_CHECK_EN
        cur_oor  = line_out_of_range(cur_key, IDX_W);
`else
        cur_oor  = 1'b0;
`endif
    end

    always_comb begin
        state_next = state;
        enter_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = ACK;
                        enter_ack  = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (counter == 8'd1) begin
                    state_next = ACK;
                    enter_ack  = 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign arr_idx = cur_key.line_addr[IDX_W-1:0];
    assign arr_we  = enter_ack && cur_key.write && !cur_oor && !rst_i;
    assign arr_re  = enter_ack && !cur_key.write && !rst_i;

    dmem_line_array #(
        .DEPTH (DEPTH),
        .LINE_W(LINE_W)
    ) u_array (
        .clk_i(clk_i),
        .we   (arr_we),
        .re   (arr_re),
        .idx  (arr_idx),
        .wdata(cur_data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            counter    <= '0;
            req_key    <= '0;
            req_data   <= '0;
            last_done  <= '0;
            done_valid <= 1'b0;
            rd_zero    <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                req_key  <= in_key;
                req_data <= data_i;
                counter  <= LOAD_CNT;
            end else if (state == BUSY) begin
                counter <= counter - 8'd1;
            end
            if (enter_ack && !cur_key.write) begin
                rd_zero <= cur_oor;
            end
            if (state == ACK) begin
                last_done  <= req_key;
                done_valid <= 1'b1;
            end
            // Dropping enable re-arms an identical request.
            if (!enable_i) begin
                done_valid <= 1'b0;
            end
        end
    end

    assign ack_o  = (state == ACK);
    assign data_o = rd_zero ? '0 : arr_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    assign err_o = (state == ACK) && line_out_of_range(req_key, IDX_W);
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Randomised bench for dmem_line_ctrl checked against a transaction-level memory model.
// Instance A runs LATENCY=10, instance B LATENCY=1; they share address/data/write lines.
`timescale 1ns/1ps
module tb_dmem_line_ctrl;

    localparam int LAT_A = 10;
    localparam int LAT_B = 1;
    localparam int DEPTH = 512;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [31:0]  addr  = '0;
    logic [255:0] wdata = '0;
    logic         wr    = 1'b0;
    logic [1:0]   en    = '0;
    logic         ack_a, ack_b;
    logic [255:0] dout_a, dout_b;
`ifdef DMEM_RANGE_CHECK_EN
    logic         err_a, err_b;
`endif

    logic [255:0] modelMem [int];
    logic [255:0] expOut [2];
    logic [27:0]  lastKey [2];
    int           lastAckCyc [2];
    int           checkCount = 0;
    int           passCount  = 0;
    int           cyc        = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_line_ctrl #(.LATENCY(LAT_A), .DEPTH(DEPTH), .LINE_W(256)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .data_i  (wdata),
        .enable_i(en[0]),
        .write_i (wr),
        .ack_o   (ack_a),
        .data_o  (dout_a)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err_o   (err_a)
`endif
    );

    dmem_line_ctrl #(.LATENCY(LAT_B), .DEPTH(DEPTH), .LINE_W(256)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .data_i  (wdata),
        .enable_i(en[1]),
        .write_i (wr),
        .ack_o   (ack_b),
        .data_o  (dout_b)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err_o   (err_b)
`endif
    );

    function automatic logic getAck(input int sel);
        return (sel == 1) ? ack_b : ack_a;
    endfunction

    function automatic logic [255:0] getOut(input int sel);
        return (sel == 1) ? dout_b : dout_a;
    endfunction

`ifdef DMEM_RANGE_CHECK_EN
    function automatic logic getErr(input int sel);
        return (sel == 1) ? err_b : err_a;
    endfunction
`endif

    // Aliasing: only the low index bits of the line address select storage.
    function automatic int modelIndex(input int sel, input logic [31:0] a);
        return sel * DEPTH + int'((a >> 5) % DEPTH);
    endfunction

    function automatic bit outOfRange(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a >> (5 + $clog2(DEPTH))) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // One request to instance sel; holds it holdExtra cycles past the ack, then optionally drops enable.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [255:0] d,
                                 input logic w, input int holdExtra, input bit dropAfter);
        int          lat, start, idx;
        bit          seen, oor;
        logic [27:0] key;
        lat  = (sel == 1) ? LAT_B : LAT_A;
        key  = {a[31:5], w};
        oor  = outOfRange(a);
        idx  = modelIndex(sel, a);
        // A still-held identical request is never re-served, and the other instance must not see new inputs.
        if (en[1-sel] || (en[sel] && key == lastKey[sel])) begin
            @(posedge clk); #1;
            en = '0;
        end
        @(posedge clk); #1;
        addr = a; wdata = d; wr = w; en[sel] = 1'b1;
        start = cyc;
        seen  = 1'b0;
        for (int k = 0; k < lat + 20 && !seen; k++) begin
            @(negedge clk);
            if (getAck(sel)) seen = 1'b1;
        end
        checkOutput("ack_seen", 256'(seen), 256'(1));
        if (seen) begin
            checkOutput("latency", 256'(cyc - start), 256'(lat));
            if (w) begin
                if (!oor) modelMem[idx] = d;
            end else begin
                expOut[sel] = oor ? '0 : modelMem[idx];
            end
            checkOutput(w ? "data_o_after_write" : "data_o_read", getOut(sel), expOut[sel]);
`ifdef DMEM_RANGE_CHECK_EN
            checkOutput("err_o", 256'(getErr(sel)), 256'(oor));
`endif
            lastAckCyc[sel] = cyc;
            lastKey[sel]    = key;
        end else begin
            en = '0;
        end
        for (int i = 0; i < holdExtra; i++) begin
            @(negedge clk);
            checkOutput("no_reack", 256'(getAck(sel)), 256'(0));
            checkOutput("data_hold", getOut(sel), expOut[sel]);
        end
        if (dropAfter) begin
            @(posedge clk); #1;
            en[sel] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           prev, ackCount;
        logic [255:0] oldLine1;
        expOut[0] = '0; expOut[1] = '0;
        lastKey[0] = '0; lastKey[1] = '0;
        lastAckCyc[0] = 0; lastAckCyc[1] = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ack_a", 256'(ack_a), 256'(0));
        checkOutput("reset_ack_b", 256'(ack_b), 256'(0));
        checkOutput("reset_dout_a", dout_a, '0);
        checkOutput("reset_dout_b", dout_b, '0);
`ifdef DMEM_RANGE_CHECK_EN
        checkOutput("reset_err_a", 256'(err_a), 256'(0));
`endif

        // Preload lines 0..7 of both instances; line 3 of A carries the A5 pattern.
        for (int s = 0; s < 2; s++) begin
            for (int l = 0; l < 8; l++) begin
                applyStimulus(s, 32'(l * 32), (s == 0 && l == 3) ? {32{8'hA5}} : rand256(), 1'b1, 0, 1'b1);
            end
        end

        // Read of line 3, then the identical request held for three more cycles.
        applyStimulus(0, 32'h60, '0, 1'b0, 3, 1'b1);
        checkOutput("a5_line", dout_a, {32{8'hA5}});

        // Writeback then refill with enable held across the switch.
        applyStimulus(0, 32'h400, 256'h1234, 1'b1, 0, 1'b0);
        prev = lastAckCyc[0];
        applyStimulus(0, 32'h400, '0, 1'b0, 0, 1'b1);
        checkOutput("ack_spacing_a", 256'(lastAckCyc[0] - prev), 256'(LAT_A + 1));
        checkOutput("refill_data", dout_a, 256'h1234);

        // Reset five cycles into a write of line 1: no ack, old contents survive.
        oldLine1 = modelMem[modelIndex(0, 32'h20)];
        @(posedge clk); #1;
        addr = 32'h20; wdata = ~oldLine1; wr = 1'b1; en = 2'b01;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en = '0;
        expOut[0] = '0; expOut[1] = '0;
        ackCount = 0;
        for (int k = 0; k < LAT_A + 5; k++) begin
            @(negedge clk);
            if (ack_a) ackCount++;
        end
        checkOutput("reset_abort_acks", 256'(ackCount), 256'(0));
        checkOutput("reset_abort_dout", dout_a, '0);
        applyStimulus(0, 32'h20, '0, 1'b0, 0, 1'b1);
        checkOutput("line1_unchanged", dout_a, oldLine1);

        // Upper address bits: alias onto line 0, or flagged and suppressed with range checking.
        applyStimulus(0, 32'h0000_4000, rand256(), 1'b1, 0, 1'b1);
        applyStimulus(0, 32'h0000_4000, '0, 1'b0, 0, 1'b1);
        applyStimulus(0, 32'h0, '0, 1'b0, 0, 1'b1);

        // LATENCY=1 instance: back-to-back reads without dropping enable.
        applyStimulus(1, 32'h0, '0, 1'b0, 0, 1'b0);
        prev = lastAckCyc[1];
        applyStimulus(1, 32'h20, '0, 1'b0, 0, 1'b1);
        checkOutput("ack_spacing_b", 256'(lastAckCyc[1] - prev), 256'(LAT_B + 1));

        for (int n = 0; n < 48; n++) begin
            int          sel, line;
            logic [31:0] a;
            sel  = (n % 4 == 3) ? 1 : 0;
            line = $urandom_range(0, 7);
            a    = 32'(line * 32) | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 14);
            applyStimulus(sel, a, rand256(), $urandom_range(0, 9) < 4, $urandom_range(0, 2),
                          $urandom_range(0, 1) == 1);
        end

        @(posedge clk); #1;
        en = '0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
